// File: rtl/vend_arbiter_if.sv
// vend_arbiter_if: every signal between vend_arbiter, the two customer panels
// and the shared vending_machine core.
//   panel side : req_*, choice_*, coin_vld_*, coin_* in; gnt_*, done_*,
//                abort, prd_out, chng_out out
//   core side  : vm_rst, vm_choice, vm_in_mny out; vm_prd, vm_chng in
// modport slave  = the arbiter
// modport master = the environment (panels + core)
interface vend_arbiter_if;
  logic       req_a, req_b;
  logic [1:0] choice_a, choice_b;
  logic       coin_vld_a, coin_vld_b;
  logic [1:0] coin_a, coin_b;
  logic       gnt_a, gnt_b;
  logic       done_a, done_b;
  logic       abort;
  logic [2:0] prd_out;
  logic [1:0] chng_out;
  logic       vm_rst;
  logic [1:0] vm_choice;
  logic [1:0] vm_in_mny;
  logic [2:0] vm_prd;
  logic [1:0] vm_chng;

  modport slave (
    input  req_a, req_b, choice_a, choice_b, coin_vld_a, coin_vld_b,
           coin_a, coin_b, vm_prd, vm_chng,
    output gnt_a, gnt_b, done_a, done_b, abort, prd_out, chng_out,
           vm_rst, vm_choice, vm_in_mny
  );

  modport master (
    output req_a, req_b, choice_a, choice_b, coin_vld_a, coin_vld_b,
           coin_a, coin_b, vm_prd, vm_chng,
    input  gnt_a, gnt_b, done_a, done_b, abort, prd_out, chng_out,
           vm_rst, vm_choice, vm_in_mny
  );
endinterface

// File: rtl/vend_arbiter.sv
// vend_arbiter: shares one vending_machine core between panels A and B.
// Round-robin grant, choice latched at grant, owner coins forwarded one
// cycle late, product/change captured on dispense, idle timeout or request
// drop aborts the session, and the core is held in reset between sessions.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - vend_arbiter_if.slave (panel and core signals)
// Parameter:
//   TIMEOUT_CYC - idle COLLECT cycles before abort (2..255)
// All outputs are registered.
module vend_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  vend_arbiter_if.slave  bus
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COLLECT, S_DONE, S_CLEAR
  } state_t;

  state_t     state, state_nxt;

  // owner/last: 0 = panel A, 1 = panel B
  logic       owner_q, owner_d;
  logic       last_b_q, last_b_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;

  logic       gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic       done_a_q, done_a_d, done_b_q, done_b_d;
  logic       abort_q, abort_d;
  logic [2:0] prd_q, prd_d;
  logic [1:0] chng_q, chng_d;
  logic       vm_rst_q, vm_rst_d;
  logic [1:0] vm_choice_q, vm_choice_d;
  logic [1:0] vm_in_mny_q, vm_in_mny_d;

  logic       win_b, own_req, own_coin_hit, dispense, timeout, in_sess;
  logic [1:0] own_coin;

  // B wins if it is the only requester, or on a tie when A was granted last.
  assign win_b        = bus.req_b & (~bus.req_a | ~last_b_q);
  assign own_req      = owner_q ? bus.req_b : bus.req_a;
  assign own_coin     = owner_q ? bus.coin_b : bus.coin_a;
  assign own_coin_hit = (owner_q ? bus.coin_vld_b : bus.coin_vld_a) &
                        (own_coin != 2'b00);
  assign dispense     = (bus.vm_prd != 3'b000);
  assign timeout      = (idle_cnt_q >= TMO);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.req_a | bus.req_b) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_COLLECT;
      S_COLLECT: if (dispense | timeout | ~own_req) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // output logic: next values of every registered output, keyed on the
  // transition being taken so the outputs line up with the new state.
  always_comb begin
    owner_d     = owner_q;
    last_b_d    = last_b_q;
    vm_choice_d = vm_choice_q;
    prd_d       = prd_q;
    chng_d      = chng_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    abort_d     = 1'b0;
    vm_in_mny_d = 2'b00;
    idle_cnt_d  = 8'd0;

    if (state == S_IDLE && state_nxt == S_LOAD) begin
      owner_d     = win_b;
      last_b_d    = win_b;
      vm_choice_d = win_b ? bus.choice_b : bus.choice_a;
    end

    if (state == S_COLLECT) begin
      if (own_coin_hit) begin
        vm_in_mny_d = own_coin;
        idle_cnt_d  = 8'd0;
      end else if (idle_cnt_q < TMO) begin
        idle_cnt_d  = idle_cnt_q + 8'd1;
      end else begin
        idle_cnt_d  = idle_cnt_q;
      end
    end

    // Dispense wins over timeout/request drop in the same cycle.
    if (state == S_COLLECT && state_nxt == S_DONE) begin
      done_a_d = ~owner_q;
      done_b_d = owner_q;
      abort_d  = ~dispense;
      prd_d    = dispense ? bus.vm_prd  : 3'b000;
      chng_d   = dispense ? bus.vm_chng : 2'b00;
    end

    in_sess  = (state_nxt == S_LOAD) || (state_nxt == S_COLLECT) ||
               (state_nxt == S_DONE);
    gnt_a_d  = in_sess & ~owner_d;
    gnt_b_d  = in_sess &  owner_d;
    vm_rst_d = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= 1'b0;
      last_b_q    <= 1'b1;
      idle_cnt_q  <= 8'd0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      abort_q     <= 1'b0;
      prd_q       <= 3'b000;
      chng_q      <= 2'b00;
      vm_rst_q    <= 1'b1;
      vm_choice_q <= 2'b00;
      vm_in_mny_q <= 2'b00;
    end else begin
      owner_q     <= owner_d;
      last_b_q    <= last_b_d;
      idle_cnt_q  <= idle_cnt_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      abort_q     <= abort_d;
      prd_q       <= prd_d;
      chng_q      <= chng_d;
      vm_rst_q    <= vm_rst_d;
      vm_choice_q <= vm_choice_d;
      vm_in_mny_q <= vm_in_mny_d;
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.done_a    = done_a_q;
  assign bus.done_b    = done_b_q;
  assign bus.abort     = abort_q;
  assign bus.prd_out   = prd_q;
  assign bus.chng_out  = chng_q;
  assign bus.vm_rst    = vm_rst_q;
  assign bus.vm_choice = vm_choice_q;
  assign bus.vm_in_mny = vm_in_mny_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// tb_vend_arbiter: drives both panels, models the vending_machine core, and
// checks session results through a scoreboard queue (expectation pushed when
// a session's stimulus starts, popped at the done pulse).
module tb_vend_arbiter;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_arbiter_if vif();

  vend_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       owner_b;
    logic       abort;
    logic [2:0] prd;
    logic [1:0] chng;
  } exp_t;
  exp_t sb[$];

  // core model: accumulates credit, dispenses {1,choice} with change in Rs.5 units
  int credit, nc;
  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction
  function automatic int price(input logic [1:0] ch);
    return (int'(ch) + 1) * 5;
  endfunction

  always @(posedge clk) begin
    if (vif.vm_rst !== 1'b0) begin
      credit      <= 0;
      vif.vm_prd  <= 3'b000;
      vif.vm_chng <= 2'b00;
    end else begin
      nc = credit + coin_val(vif.vm_in_mny);
      credit <= nc;
      if (nc >= price(vif.vm_choice)) begin
        vif.vm_prd  <= {1'b1, vif.vm_choice};
        vif.vm_chng <= 2'((nc - price(vif.vm_choice)) / 5);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    vif.req_a = 0; vif.req_b = 0; vif.choice_a = 0; vif.choice_b = 0;
    vif.coin_vld_a = 0; vif.coin_vld_b = 0; vif.coin_a = 0; vif.coin_b = 0;
  endtask

  task automatic wait_done(input int max, output logic seen, output int n);
    seen = 0; n = 0;
    while (!seen && n < max) begin
      step(); n++;
      if (vif.done_a === 1'b1 || vif.done_b === 1'b1) seen = 1;
    end
  endtask

  task automatic coin(input logic b, input logic [1:0] c);
    if (b) begin vif.coin_vld_b = 1; vif.coin_b = c; end
    else   begin vif.coin_vld_a = 1; vif.coin_a = c; end
    step();
    vif.coin_vld_a = 0; vif.coin_vld_b = 0; vif.coin_a = 0; vif.coin_b = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 0; step(); step();
    total++; if ({vif.gnt_a, vif.gnt_b, vif.done_a, vif.done_b, vif.abort} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {vif.gnt_a, vif.gnt_b, vif.done_a, vif.done_b, vif.abort}); end
    total++; if ({vif.prd_out, vif.chng_out} !== 5'b0) begin
      bad++; $display("FAIL reset_capt: got %b want 00000", {vif.prd_out, vif.chng_out}); end
    total++; if ({vif.vm_rst, vif.vm_choice, vif.vm_in_mny} !== 5'b10000) begin
      bad++; $display("FAIL reset_vm: got %b want 10000", {vif.vm_rst, vif.vm_choice, vif.vm_in_mny}); end
    rst = 1; step();
    total++; if ({vif.gnt_a, vif.gnt_b, vif.vm_rst} !== 3'b001) begin
      bad++; $display("FAIL reset_idle: got %b want 001", {vif.gnt_a, vif.gnt_b, vif.vm_rst}); end
  endtask

  task automatic test_single_a();
    logic seen; int n; exp_t e;
    vif.choice_a = 2'b10;
    sb.push_back('{owner_b:1'b0, abort:1'b0, prd:3'b110, chng:2'b00});
    vif.req_a = 1; step();
    total++; if ({vif.gnt_a, vif.gnt_b, vif.vm_rst, vif.vm_choice} !== 5'b10010) begin
      bad++; $display("FAIL single_load: got %b want 10010", {vif.gnt_a, vif.gnt_b, vif.vm_rst, vif.vm_choice}); end
    vif.choice_a = 2'b11;   // must not affect the session
    step();
    for (int i = 0; i < 3; i++) begin
      coin(1'b0, 2'b01);
      total++; if (vif.vm_in_mny !== 2'b01) begin
        bad++; $display("FAIL single_coin%0d: got %b want 01", i, vif.vm_in_mny); end
      step();
      total++; if (vif.vm_in_mny !== 2'b00) begin
        bad++; $display("FAIL single_gap%0d: got %b want 00", i, vif.vm_in_mny); end
    end
    total++; if (vif.vm_choice !== 2'b10) begin
      bad++; $display("FAIL single_choice_hold: got %b want 10", vif.vm_choice); end
    wait_done(8, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL single_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL single_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
    end
    vif.req_a = 0; step();
    total++; if ({vif.done_a, vif.gnt_a, vif.vm_rst, vif.prd_out} !== 6'b001110) begin
      bad++; $display("FAIL single_clear: got %b want 001110", {vif.done_a, vif.gnt_a, vif.vm_rst, vif.prd_out}); end
    step();
  endtask

  task automatic test_change();
    logic seen; int n; exp_t e;
    vif.choice_a = 2'b00;
    sb.push_back('{owner_b:1'b0, abort:1'b0, prd:3'b100, chng:2'b11});
    vif.req_a = 1; step(); step();
    coin(1'b0, 2'b11);
    total++; if (vif.vm_in_mny !== 2'b11) begin
      bad++; $display("FAIL change_coin: got %b want 11", vif.vm_in_mny); end
    wait_done(8, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL change_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL change_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
    end
    vif.req_a = 0; step(); step();
  endtask

  // Tie from reset: A first; A keeps requesting, so the next tie goes to B.
  // B's coins during A's session must never reach the core.
  task automatic test_round_robin();
    logic seen; int n; exp_t e;
    idle_inputs(); rst = 0; step(); rst = 1; step();
    vif.choice_a = 2'b01; vif.choice_b = 2'b01;
    sb.push_back('{owner_b:1'b0, abort:1'b0, prd:3'b101, chng:2'b00});
    vif.req_a = 1; vif.req_b = 1; step();
    total++; if ({vif.gnt_a, vif.gnt_b} !== 2'b10) begin
      bad++; $display("FAIL rr_first: got %b want 10", {vif.gnt_a, vif.gnt_b}); end
    step();
    for (int i = 0; i < 2; i++) begin
      coin(1'b1, 2'b11);
      total++; if (vif.vm_in_mny !== 2'b00) begin
        bad++; $display("FAIL rr_nonowner%0d: got %b want 00", i, vif.vm_in_mny); end
      step();
    end
    coin(1'b0, 2'b10);
    wait_done(8, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL rr_a_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL rr_a_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
    end
    step(); step();
    total++; if ({vif.gnt_a, vif.gnt_b} !== 2'b00) begin
      bad++; $display("FAIL rr_gap: got %b want 00", {vif.gnt_a, vif.gnt_b}); end
    sb.push_back('{owner_b:1'b1, abort:1'b0, prd:3'b101, chng:2'b00});
    step();
    total++; if ({vif.gnt_a, vif.gnt_b, vif.vm_choice} !== 4'b0101) begin
      bad++; $display("FAIL rr_second: got %b want 0101", {vif.gnt_a, vif.gnt_b, vif.vm_choice}); end
    step();
    coin(1'b1, 2'b01); step(); step();
    total++; if ({vif.done_a, vif.done_b} !== 2'b00) begin
      bad++; $display("FAIL rr_b_zero_credit: got %b want 00", {vif.done_a, vif.done_b}); end
    coin(1'b1, 2'b01);
    wait_done(8, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL rr_b_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL rr_b_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
    end
    vif.req_a = 0; vif.req_b = 0; step(); step();
  endtask

  task automatic test_timeout();
    logic seen; int n; exp_t e;
    vif.choice_a = 2'b11;
    sb.push_back('{owner_b:1'b0, abort:1'b1, prd:3'b000, chng:2'b00});
    vif.req_a = 1; step();
    wait_done(TMO + 10, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL timeout_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL timeout_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
      total++; if (n < TMO || n > TMO + 4) begin
        bad++; $display("FAIL timeout_len: got %0d cycles want %0d..%0d", n, TMO, TMO + 4); end
    end
    vif.req_a = 0; step();
    total++; if ({vif.vm_rst, vif.gnt_a, vif.done_a} !== 3'b100) begin
      bad++; $display("FAIL timeout_clear: got %b want 100", {vif.vm_rst, vif.gnt_a, vif.done_a}); end
    step();
  endtask

  task automatic test_req_drop();
    logic seen; int n; exp_t e;
    vif.choice_a = 2'b11;
    sb.push_back('{owner_b:1'b0, abort:1'b1, prd:3'b000, chng:2'b00});
    vif.req_a = 1; step(); step();
    coin(1'b0, 2'b01);
    vif.req_a = 0;
    wait_done(5, seen, n);
    e = sb.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL drop_done: no done in %0d cycles", n); end
    else begin
      total++; if ({vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out} !== {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}) begin
        bad++; $display("FAIL drop_result: got %b want %b", {vif.done_a, vif.done_b, vif.abort, vif.prd_out, vif.chng_out}, {~e.owner_b, e.owner_b, e.abort, e.prd, e.chng}); end
    end
    step(); step();
  endtask

  task automatic test_reset_mid();
    vif.choice_a = 2'b10;
    vif.req_a = 1; step(); step();
    coin(1'b0, 2'b01);
    #2 rst = 0; #1;
    total++; if ({vif.gnt_a, vif.vm_rst, vif.done_a, vif.vm_in_mny} !== 5'b01000) begin
      bad++; $display("FAIL rstmid_now: got %b want 01000", {vif.gnt_a, vif.vm_rst, vif.done_a, vif.vm_in_mny}); end
    vif.req_a = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({vif.done_a, vif.gnt_a} !== 2'b00) begin
        bad++; $display("FAIL rstmid_hold%0d: got %b want 00", i, {vif.done_a, vif.gnt_a}); end
    end
    rst = 1; step(); step();
    total++; if ({vif.done_a, vif.gnt_a, vif.vm_rst} !== 3'b001) begin
      bad++; $display("FAIL rstmid_after: got %b want 001", {vif.done_a, vif.gnt_a, vif.vm_rst}); end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_change();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_reset_mid();
    total++; if (sb.size() != 0) begin
      bad++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_arbiter.md
# vend_arbiter

Shares one `vending_machine` core between two customer front panels (A and B). Grants the core to one panel at a time with round-robin priority, latches that panel's product choice, and forwards its coins to the core. It captures the product and change codes when the core dispenses, then clears the core for the next session. Sits between the panel logic and the `vending_machine` instance; the core's active-high `rst` is driven only by this block.

## Interface
- `TIMEOUT_CYC`, 16: idle cycles (no coin from the granted panel) before a session is aborted; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_a`, `req_b` in 1: level request; held high for the whole session.
- `choice_a`, `choice_b` in 2: product code (00 Rs.5, 01 Rs.10, 10 Rs.15, 11 Rs.20).
- `coin_vld_a`, `coin_vld_b` in 1: one-cycle coin strobe.
- `coin_a`, `coin_b` in 2: coin code when strobed (01 Rs.5, 10 Rs.10, 11 Rs.20; 00 is ignored).
- `gnt_a`, `gnt_b` out 1: session owner; at most one is high.
- `done_a`, `done_b` out 1: one-cycle session-end pulse to the owner.
- `abort` out 1: valid with `done_*`; 1 means the session ended without dispense.
- `prd_out` out 3: captured product code; valid from `done_*` and held until the next `done_*`.
- `chng_out` out 2: captured change code (00 none, 01 Rs.5, 10 Rs.10, 11 Rs.15); held like `prd_out`.
- `vm_rst` out 1: active-high reset to the core.
- `vm_choice` out 2: choice presented to the core.
- `vm_in_mny` out 2: coin presented to the core; 00 means no coin.
- `vm_prd` in 3: core product output; nonzero means dispensed.
- `vm_chng` in 2: core change output.

## Operation
- States:
  - IDLE: `vm_rst`=1; no grant.
  - LOAD: `vm_rst`=0; `vm_choice` is driven.
  - COLLECT: coins are forwarded; waits for dispense.
  - DONE: pulses `done_*`.
  - CLEAR: `vm_rst`=1 for one cycle, then IDLE.
- IDLE -> LOAD when any `req_*` is high.
  - Winner: the single requester, or on a tie the panel not granted last.
  - The last-granted pointer resets to B, so A wins the first tie.
- Choice is latched on the grant edge. Later changes to `choice_*` have no effect during the session.
- LOAD -> COLLECT unconditionally after one cycle.
- COLLECT:
  - Owner `coin_vld` with nonzero coin: the coin is registered onto `vm_in_mny` for exactly one cycle, and the idle counter clears.
  - All other cycles: `vm_in_mny`=00.
  - Coins and choices from the non-owner are ignored and dropped, not queued.
- COLLECT -> DONE when the sampled `vm_prd` != 0.
  - `vm_prd` and `vm_chng` are captured into `prd_out` and `chng_out`.
  - `abort`=0.
- COLLECT -> DONE with `abort`=1 in either case:
  - The idle counter reaches `TIMEOUT_CYC`.
  - The owner's `req_*` drops.
  - On abort, `prd_out`=000 and `chng_out`=00 are captured.
- Dispense detection has priority over both abort causes in the same cycle.
- DONE -> CLEAR -> IDLE. The grant deasserts on entry to CLEAR.
- A pending request from the other panel is served from IDLE, giving a 2-cycle gap between sessions.
- Idle counter: 8 bits. It counts only in COLLECT cycles without an owner coin, and saturates at `TIMEOUT_CYC`.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE;
  - `gnt_*`=0, `done_*`=0, `abort`=0;
  - `prd_out`=000, `chng_out`=00;
  - `vm_rst`=1, `vm_choice`=00, `vm_in_mny`=00;
  - idle counter 0, last-granted pointer = B.
- Reset mid-session drops the grant immediately, with no `done_*`. The captured outputs are lost.
- With `req_a` rising at edge N:
  - `gnt_a`=1 after edge N+1 (LOAD).
  - COLLECT from edge N+2.
- A coin strobed in cycle M appears on `vm_in_mny` in cycle M+1.
- Dispense seen in cycle K:
  - `done_*`, `abort`, `prd_out` and `chng_out` update after edge K+1.
  - `gnt_*` falls after edge K+2, the CLEAR cycle.
- All outputs are registered.
- `done_*` is never high when the matching `gnt_*` was low in the previous cycle.

## Test plan
- A alone, `choice_a`=10, three Rs.5 coins (coin 01), core dispenses -> one `done_a` pulse, `abort`=0, `prd_out` nonzero, `chng_out`=00, `vm_in_mny` shows 01 three times.
- A, `choice_a`=00, one Rs.20 coin (11) -> `done_a`, `chng_out`=11 (Rs.15 change).
- `req_a` and `req_b` rise on the same edge from reset -> A granted first. After A's `done_a` plus 2 cycles, `gnt_b`=1. On the next simultaneous request, B wins.
- B strobes coins while A owns the core -> `vm_in_mny` stays 00 for every B strobe, and B's session later starts with zero credit.
- A granted, no coins for 16 cycles -> `done_a` with `abort`=1, `prd_out`=000, `vm_rst`=1 in the CLEAR cycle.
- `req_a` dropped after one coin -> abort pulse. Separately, assert `rst`=0 mid-COLLECT -> `gnt_a`=0 and `vm_rst`=1 immediately, no `done_a`.
